// File: rtl/str_num_parser.sv
// rtl/str_num_parser.sv - streaming ASCII decimal/0x-hex token parser, one record per token
// Define STR_NUM_PARSER_SIGNED_EN to accept a leading '-' and emit two's-complement results.
module str_num_parser #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_value,
  output logic [1:0]        out_err,
  output logic              out_last
);

`ifdef STR_NUM_PARSER_SIGNED_EN
  localparam bit SignedEn = 1'b1;
`else
  localparam bit SignedEn = 1'b0;
`endif

  localparam int EW = DATA_W + 4;
  localparam logic [1:0] ERR_OK = 2'd0, ERR_BAD = 2'd1, ERR_OVF = 2'd2, ERR_EMPTY = 2'd3;
  localparam logic [DATA_W-1:0] MAG_LIM = {1'b1, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_SKIP, S_ZERO, S_DEC, S_HEX0, S_HEX, S_BAD, S_EMIT, S_SGN} state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   acc_q;
  logic                ovf_q, sign_q;
  logic                in_ready_q, out_valid_q, out_last_q;
  logic [DATA_W-1:0]   out_value_q;
  logic [1:0]          out_err_q;

  logic                is_delim, is_dec, is_alpha_hex, hex_mode, is_dig, is_minus;
  logic [3:0]          dig_v;
  logic [EW-1:0]       ext;
  logic                ovf_d;
  logic [DATA_W-1:0]   acc_d;
  logic [DATA_W+1:0]   tok_rec, dig_rec;
  logic                emit, load_acc, set_sign;
  logic [1:0]          rec_err;
  logic [DATA_W-1:0]   rec_val;
  state_t              nxt_state;

  // Final {err, value} of a token; a clamped or too-large magnitude reports OVERFLOW.
  function automatic logic [DATA_W+1:0] fin_rec(input logic [DATA_W-1:0] a, input logic o,
                                                input logic s);
    if (o || (s && (a > MAG_LIM))) return {ERR_OVF, {DATA_W{1'b1}}};
    return {ERR_OK, (s ? -a : a)};
  endfunction

  always_comb begin
    is_delim     = in_char inside {8'h20, 8'h09, 8'h0A, 8'h0D, 8'h2C};
    is_dec       = in_char inside {[8'h30:8'h39]};
    is_alpha_hex = in_char inside {[8'h41:8'h46], [8'h61:8'h66]};
    is_minus     = SignedEn && (in_char == 8'h2D);
    hex_mode     = state_q inside {S_HEX0, S_HEX};
    is_dig       = is_dec || (hex_mode && is_alpha_hex);
    dig_v        = is_dec ? in_char[3:0] : in_char[3:0] + 4'd9;
    // Four guard bits catch any carry past DATA_W from one *10+d or <<4|d step.
    ext          = hex_mode ? {acc_q, dig_v} : (EW'(acc_q) * EW'(10) + EW'(dig_v));
    ovf_d        = ovf_q | (|ext[EW-1:DATA_W]);
    acc_d        = ovf_d ? {DATA_W{1'b1}} : ext[DATA_W-1:0];
    tok_rec      = fin_rec(acc_q, ovf_q, sign_q);
    dig_rec      = fin_rec(acc_d, ovf_d, sign_q);

    nxt_state = state_q;
    emit      = 1'b0;
    load_acc  = 1'b0;
    set_sign  = 1'b0;
    rec_err   = ERR_BAD;
    rec_val   = '0;
    if (is_delim) begin
      if (state_q == S_SKIP) begin
        emit    = in_last;
        rec_err = ERR_EMPTY;
      end else if (state_q inside {S_ZERO, S_DEC, S_HEX}) begin
        emit               = 1'b1;
        {rec_err, rec_val} = tok_rec;
      end else begin
        emit = 1'b1;
      end
    end else if (is_dig && (state_q != S_BAD)) begin
      load_acc           = 1'b1;
      emit               = in_last;
      {rec_err, rec_val} = dig_rec;
      if (hex_mode) nxt_state = S_HEX;
      else if ((state_q inside {S_SKIP, S_SGN}) && (in_char == 8'h30)) nxt_state = S_ZERO;
      else nxt_state = S_DEC;
    end else if ((state_q == S_ZERO) && ((in_char == 8'h78) || (in_char == 8'h58))) begin
      emit      = in_last;
      nxt_state = S_HEX0;
    end else if ((state_q == S_SKIP) && is_minus) begin
      set_sign  = 1'b1;
      emit      = in_last;
      nxt_state = S_SGN;
    end else begin
      emit      = in_last;
      nxt_state = S_BAD;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_SKIP;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      sign_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_value_q <= '0;
      out_err_q   <= ERR_OK;
      out_last_q  <= 1'b0;
    end else if (state_q == S_EMIT) begin
      if (out_ready) begin
        state_q     <= S_SKIP;
        acc_q       <= '0;
        ovf_q       <= 1'b0;
        sign_q      <= 1'b0;
        out_valid_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end
    end else if (in_valid && in_ready_q) begin
      if (load_acc) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
      end
      if (set_sign) sign_q <= 1'b1;
      if (emit) begin
        state_q     <= S_EMIT;
        out_valid_q <= 1'b1;
        out_value_q <= rec_val;
        out_err_q   <= rec_err;
        out_last_q  <= in_last;
        in_ready_q  <= 1'b0;
      end else begin
        state_q <= nxt_state;
      end
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_value = out_value_q;
  assign out_err   = out_err_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_str_num_parser.sv
// tb/tb_str_num_parser.sv - directed self-checking bench for str_num_parser (DATA_W=32)
module tb_str_num_parser;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_char = 8'h00;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_value;
  logic [1:0]  out_err;
  logic        out_last;

  int tests = 0;
  int fails = 0;
  logic [34:0] recq[$];

  str_num_parser #(.DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_value(out_value),
    .out_err(out_err), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (rst_n && out_valid && out_ready) recq.push_back({out_last, out_err, out_value});

  initial begin
    #400000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] c, input logic last);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("in_ready_timeout", in_ready, 1'b1);
    in_valid = 1'b1;
    in_char  = c;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_str(input string s, input logic last_on_end);
    for (int i = 0; i < s.len(); i++) send(s[i], last_on_end && (i == s.len() - 1));
  endtask

  task automatic expect_rec(input string tag, input logic [31:0] v, input logic [1:0] e,
                            input logic l);
    int n;
    logic [34:0] r;
    n = 0;
    while (recq.size() == 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (recq.size() == 0) check({tag, "_timeout"}, recq.size(), 1);
    else begin
      r = recq.pop_front();
      check({tag, "_val"}, r[31:0], v);
      check({tag, "_err"}, r[33:32], e);
      check({tag, "_last"}, r[34], l);
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_value", out_value, 32'h0);
    check("rst_out_err", out_err, 2'd0);
    check("rst_out_last", out_last, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    send_str("42 0x1F,7\n", 1'b1);
    expect_rec("r42", 32'd42, 2'd0, 1'b0);
    expect_rec("r1f", 32'd31, 2'd0, 1'b0);
    expect_rec("r7", 32'd7, 2'd0, 1'b1);

    send_str("4294967296 0xFFFFFFFF 0x100000000 ", 1'b0);
    expect_rec("dec_ovf", 32'hFFFF_FFFF, 2'd2, 1'b0);
    expect_rec("hex_max", 32'hFFFF_FFFF, 2'd0, 1'b0);
    expect_rec("hex_ovf", 32'hFFFF_FFFF, 2'd2, 1'b0);

    send_str("12a3 0x 5 ", 1'b0);
    expect_rec("bad_mid", 32'd0, 2'd1, 1'b0);
    expect_rec("bad_hex0", 32'd0, 2'd1, 1'b0);
    expect_rec("recover", 32'd5, 2'd0, 1'b0);

    out_ready = 1'b0;
    send_str("8 ", 1'b0);
    check("lat_out_valid", out_valid, 1'b1);
    check("lat_in_ready", in_ready, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("bp_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
      check("bp_value", out_value, 32'd8);
      check("bp_err", out_err, 2'd0);
    end
    out_ready = 1'b1;
    send_str("6 ", 1'b0);
    expect_rec("bp_rec8", 32'd8, 2'd0, 1'b0);
    expect_rec("bp_rec6", 32'd6, 2'd0, 1'b0);

    send_str("  ", 1'b1);
    expect_rec("empty_last", 32'd0, 2'd3, 1'b1);
    send_str("9", 1'b1);
    expect_rec("digit_last", 32'd9, 2'd0, 1'b1);
    send_str("1z", 1'b1);
    expect_rec("bad_last", 32'd0, 2'd1, 1'b1);
    send_str("007 ", 1'b0);
    expect_rec("lead_zero", 32'd7, 2'd0, 1'b0);

    send_str("12", 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_str("3 ", 1'b0);
    expect_rec("after_rst", 32'd3, 2'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_no_extra", recq.size(), 0);

    out_ready = 1'b0;
    send_str("4 ", 1'b0);
    check("emit_pending", out_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check("emit_rst_valid", out_valid, 1'b0);
    check("emit_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("emit_rst_drop", recq.size(), 0);

    send_str("-5 -0x10 ", 1'b0);
`ifdef STR_NUM_PARSER_SIGNED_EN
    expect_rec("neg5", 32'hFFFF_FFFB, 2'd0, 1'b0);
    expect_rec("neg_hex", 32'hFFFF_FFF0, 2'd0, 1'b0);
`else
    expect_rec("minus_bad", 32'd0, 2'd1, 1'b0);
    expect_rec("minus_hex_bad", 32'd0, 2'd1, 1'b0);
`endif

    repeat (5) @(posedge clk);
    #1;
    check("final_empty", recq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
